// File: rtl/display_sched_pkg.sv
// Shared types for the display line prefetch scheduler.
// State encoding and line-length derivation.
package display_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACK,
    S_DRAIN
  } state_t;

  localparam int LEN_W = 12;
  localparam int CNT_W = 3;

  function automatic int line_words(
    input int h_active,
    input int pix_per_word
  );
    return h_active / pix_per_word;
  endfunction

endpackage

// File: rtl/display_sync_edge_det.sv
// Registers vsync/DE and emits frame-start,
// line-start and line-consume pulses.
module display_sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  input  logic de,
  output logic fs,
  output logic line_start,
  output logic line_consume
);

  logic vs_q;
  logic de_q;

  // vsync idles high, so reset to the inactive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      vs_q <= vs;
      de_q <= de;
    end
  end

  assign fs           = vs_q & ~vs;
  assign line_start   = de & ~de_q;
  assign line_consume = de_q & ~de;

endmodule

// File: rtl/display_line_fetch_sched.sv
// Frame-buffer line prefetch scheduler: one DMA
// request per active line, credit-limited.
module display_line_fetch_sched #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int PIX_PER_WORD   = 2,
  parameter int AW             = 32,
  parameter int LINE_STRIDE    = 1280,
  parameter int PREFETCH_LINES = 2
) (
  input  logic          in_pclk,
  input  logic          in_rstn,
  input  logic          in_enable,
  input  logic          in_vs,
  input  logic          in_de,
  input  logic [AW-1:0] in_fb_base,
  output logic          out_req_valid,
  output logic [AW-1:0] out_req_addr,
  output logic [11:0]   out_req_len,
  input  logic          in_req_ready,
  input  logic          in_line_done,
  output logic [11:0]   out_line_idx,
  output logic          out_busy,
  output logic          out_underrun,
  input  logic          in_underrun_clr
);

  import display_sched_pkg::*;

  localparam int LINE_WORDS =
    line_words(H_ACTIVE, PIX_PER_WORD);
  localparam int IW = $clog2(V_ACTIVE + 1);

  state_t state;
  state_t state_nx;

  logic [AW-1:0]    addr;
  logic [IW-1:0]    issued;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_nx;
  logic [CNT_W-1:0] rdy;
  logic [CNT_W-1:0] rdy_nx;
  logic [11:0]      line_idx;
  logic             underrun;
  logic             fs_pend;

  logic fs;
  logic line_start;
  logic line_consume;
  logic accept;
  logic load;

  display_sync_edge_det u_edge (
    .clk          (in_pclk),
    .rst_n        (in_rstn),
    .vs           (in_vs),
    .de           (in_de),
    .fs           (fs),
    .line_start   (line_start),
    .line_consume (line_consume)
  );

  assign accept = (state == S_WAIT_ACK) && in_req_ready;
  assign load   = (state == S_LOAD);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (fs && in_enable) state_nx = S_LOAD;
      end
      S_LOAD: state_nx = S_ISSUE;
      S_ISSUE: begin
        if (fs)
          state_nx = S_LOAD;
        else if (issued == IW'(V_ACTIVE))
          state_nx = S_DRAIN;
        else if (occ < CNT_W'(PREFETCH_LINES))
          state_nx = S_WAIT_ACK;
      end
      // a pending request is never withdrawn
      S_WAIT_ACK: begin
        if (in_req_ready)
          state_nx = (fs || fs_pend) ? S_LOAD : S_ISSUE;
      end
      S_DRAIN: begin
        if (fs) state_nx = in_enable ? S_LOAD : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    occ_nx = occ;
    if (accept)
      occ_nx = occ_nx + CNT_W'(1);
    if (line_consume && occ != '0)
      occ_nx = occ_nx - CNT_W'(1);
  end

  // done and consume together leave rdy unchanged
  always_comb begin
    rdy_nx = rdy;
    if (in_line_done && !line_consume) begin
      if (rdy < occ) rdy_nx = rdy + CNT_W'(1);
    end else if (line_consume && !in_line_done) begin
      if (rdy != '0) rdy_nx = rdy - CNT_W'(1);
    end
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      fs_pend <= 1'b0;
    end else if (state == S_WAIT_ACK) begin
      fs_pend <= accept ? 1'b0 : (fs_pend | fs);
    end else begin
      fs_pend <= 1'b0;
    end
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      addr     <= '0;
      issued   <= '0;
      line_idx <= '0;
    end else if (load) begin
      addr     <= in_fb_base;
      issued   <= '0;
      line_idx <= '0;
    end else if (accept) begin
      addr     <= addr + AW'(LINE_STRIDE);
      issued   <= issued + IW'(1);
      line_idx <= line_idx + 12'd1;
    end
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      occ <= '0;
      rdy <= '0;
    end else if (load) begin
      occ <= '0;
      rdy <= '0;
    end else begin
      occ <= occ_nx;
      rdy <= rdy_nx;
    end
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      underrun <= 1'b0;
    end else if (line_start && rdy == '0
                 && state != S_IDLE) begin
      underrun <= 1'b1;
    end else if (in_underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  assign out_req_valid = (state == S_WAIT_ACK);
  assign out_req_addr  = addr;
  assign out_req_len   = 12'(LINE_WORDS);
  assign out_line_idx  = line_idx;
  assign out_busy      = (state != S_IDLE);
  assign out_underrun  = underrun;

endmodule
